// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master bridge: FSM states, bus width
// defaults and the PWM/timer slave register map.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam int ADR_W_DEF = 16;
  localparam int DAT_W_DEF = 16;

  localparam logic [15:0] REG_CTRL    = 16'h0000;
  localparam logic [15:0] REG_DIVISOR = 16'h0002;
  localparam logic [15:0] REG_PERIOD  = 16'h0004;
  localparam logic [15:0] REG_DC      = 16'h0006;

endpackage

// File: rtl/wb_master_bridge_if.sv
// Host command/response port plus Wishbone initiator signals of the bridge.
// The master modport is the bridge's view; slave is the environment's view.
interface wb_master_bridge_if #(
  parameter int ADR_W = wb_pkg::ADR_W_DEF,
  parameter int DAT_W = wb_pkg::DAT_W_DEF
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [ADR_W-1:0] cmd_adr;
  logic [DAT_W-1:0] cmd_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DAT_W-1:0] rsp_data;
  logic             rsp_err;

  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [ADR_W-1:0] wb_adr;
  logic [DAT_W-1:0] wb_wdata;
  logic             wb_ack;
  logic [DAT_W-1:0] wb_rdata;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_data, rsp_ready, wb_ack, wb_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           wb_cyc, wb_stb, wb_we, wb_adr, wb_wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_data, rsp_ready, wb_ack, wb_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           wb_cyc, wb_stb, wb_we, wb_adr, wb_wdata
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Clearable saturating cycle counter; tc flags that TIMEOUT-1 has been reached.
module wb_timeout_cnt #(
  parameter  int TIMEOUT = 16,
  localparam int CW      = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  // Saturates at the terminal count so a long stall can never wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator: one host command becomes one
// bus cycle, answered with read data, write completion or a timeout error.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF
) (
  input  logic                i_wb_clk,
  input  logic                i_wb_rst_n,
  wb_master_bridge_if.master  bus
);

  state_t           state;
  logic             cmd_ready;
  logic             rsp_valid;
  logic             rsp_err;
  logic [DAT_W-1:0] rsp_data;
  logic             cyc;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] wdata;

  logic accept;
  logic cnt_en;
  logic tc;

  assign accept = (state == ST_IDLE) && cmd_ready && bus.cmd_valid;
  assign cnt_en = (state == ST_REQ) && !bus.wb_ack;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk   (i_wb_clk),
    .rst_n (i_wb_rst_n),
    .clr   (accept),
    .en    (cnt_en),
    .tc    (tc)
  );

  // NOTE: every output is a flop reset asynchronously, so a reset in the middle
  // of a bus cycle drops cyc/stb at once without waiting for a clock edge.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      cyc       <= 1'b0;
      we        <= 1'b0;
      adr       <= '0;
      wdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            cyc       <= 1'b1;
            we        <= bus.cmd_we;
            adr       <= bus.cmd_adr;
            wdata     <= bus.cmd_we ? bus.cmd_data : '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack on the terminal-count cycle still completes normally.
          if (bus.wb_ack) begin
            cyc       <= 1'b0;
            we        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= we ? '0 : bus.wb_rdata;
            state     <= ST_RSP;
          end else if (tc) begin
            cyc       <= 1'b0;
            we        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_data  = rsp_data;
  assign bus.wb_cyc    = cyc;
  assign bus.wb_stb    = cyc;
  assign bus.wb_we     = we;
  assign bus.wb_adr    = adr;
  assign bus.wb_wdata  = wdata;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized scoreboard bench for wb_master_bridge: a slave model acks after a
// planned delay, and a monitor checks responses and bus-cycle lengths.
module tb_wb_master_bridge;
  import wb_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  typedef struct {
    bit          we;
    logic [15:0] adr;
    logic [15:0] data;
    logic [15:0] rdata;
    int          delay;
  } plan_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  bit   force_hold;
  bit   sticky;

  int checks = 0;
  int errors = 0;

  plan_t       plan_q[$];
  exp_t        exp_q[$];
  int          len_q[$];
  logic [15:0] last_adr;

  wb_master_bridge_if #(.ADR_W(16), .DAT_W(16)) bus ();

  wb_master_bridge #(.TIMEOUT(TIMEOUT), .ADR_W(16), .DAT_W(16)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the response and cycle length follow directly from the
  // planned ack delay compared with the timeout budget.
  task automatic issue(input bit we, input logic [15:0] adr, input logic [15:0] data,
                       input int delay, input logic [15:0] rdata);
    plan_t p;
    exp_t  e;
    bit    to;
    int    n;
    to      = (delay >= TIMEOUT);
    p.we    = we;  p.adr = adr;  p.data = data;  p.rdata = rdata;  p.delay = delay;
    e.err   = to;
    e.data  = (to || we) ? 16'h0 : rdata;
    plan_q.push_back(p);
    exp_q.push_back(e);
    len_q.push_back(to ? TIMEOUT : delay + 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_data  = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 300) begin
        check("cmd_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'($urandom);
    bus.cmd_adr   = 16'($urandom);
    bus.cmd_data  = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_scoreboard", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Response-ready driver: random back-pressure unless a hold is requested.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready = force_hold ? 1'b0 : (($urandom % 3) != 0);
    end
  end

  // Slave model: acks on the planned REQ cycle, random/sticky acks when idle.
  initial begin
    plan_t cur;
    int    scnt;
    scnt = 0;
    cur.we = 0; cur.adr = '0; cur.data = '0; cur.rdata = '0; cur.delay = NEVER;
    bus.wb_ack   = 1'b0;
    bus.wb_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        plan_q.delete();
        scnt       = 0;
        bus.wb_ack = sticky;
      end else if (bus.wb_cyc) begin
        if (scnt == 0) begin
          if (plan_q.size() == 0) begin
            check("unexpected_cyc", 1, 0);
            cur.delay = NEVER;
          end else begin
            cur = plan_q.pop_front();
            check("wb_we",    bus.wb_we,    cur.we);
            check("wb_adr",   bus.wb_adr,   cur.adr);
            check("wb_wdata", bus.wb_wdata, cur.we ? cur.data : 16'h0);
            last_adr = cur.adr;
          end
        end
        bus.wb_ack   = (scnt == cur.delay);
        bus.wb_rdata = (scnt == cur.delay) ? cur.rdata : 16'($urandom);
        scnt++;
      end else begin
        scnt         = 0;
        bus.wb_ack   = sticky || (($urandom % 4) == 0);
        bus.wb_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: checks bus-cycle shape and pops/compares responses.
  initial begin
    int   cyc_len;
    logic prev_cyc;
    logic prev_valid;
    exp_t e;
    cyc_len = 0; prev_cyc = 0; prev_valid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        len_q.delete();
        cyc_len = 0; prev_cyc = 0; prev_valid = 0;
      end else begin
        check("stb_eq_cyc", bus.wb_stb, bus.wb_cyc);
        if (bus.wb_cyc) begin
          cyc_len++;
          check("ready_in_cyc", bus.cmd_ready, 0);
        end else begin
          check("we_cleared", bus.wb_we, 0);
          if (prev_cyc) begin
            if (len_q.size() == 0) check("cyc_len_unplanned", 1, 0);
            else check("cyc_len", cyc_len, len_q.pop_front());
            check("adr_hold", bus.wb_adr, last_adr);
            cyc_len = 0;
          end
        end
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_rsp", 1, 0);
          end else begin
            e = exp_q[0];
            check("rsp_data",        bus.rsp_data,  e.data);
            check("rsp_err",         bus.rsp_err,   e.err);
            check("ready_in_rsp",    bus.cmd_ready, 0);
            if (!prev_valid) check("rsp_on_cyc_end", prev_cyc, 1);
            if (bus.rsp_ready) void'(exp_q.pop_front());
          end
        end
        prev_valid = bus.rsp_valid;
        prev_cyc   = bus.wb_cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; force_hold = 1'b0; sticky = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data",  bus.rsp_data,  0);
    check("rst_rsp_err",   bus.rsp_err,   0);
    check("rst_cyc",       bus.wb_cyc,    0);
    check("rst_stb",       bus.wb_stb,    0);
    check("rst_we",        bus.wb_we,     0);
    check("rst_adr",       bus.wb_adr,    0);
    check("rst_wdata",     bus.wb_wdata,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", bus.cmd_ready, 1);

    // Directed: fast write, delayed read, timeout, ack on terminal count
    issue(1'b1, REG_DIVISOR, 16'h00FF, 0, 16'hA5A5);
    issue(1'b0, REG_PERIOD,  16'h0000, 3, 16'h1234);
    issue(1'b0, 16'h0008,    16'h0000, NEVER, 16'h0000);
    drain();
    force_hold = 1'b1;
    issue(1'b0, REG_DC, 16'h0000, TIMEOUT - 1, 16'hBEEF);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_rsp_seen", bus.rsp_valid, 1);
    repeat (5) @(negedge clk);
    check("hold_rsp_still_valid", bus.rsp_valid, 1);
    @(posedge clk); #2;
    force_hold = 1'b0;
    drain();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      case ($urandom % 5)
        0: a = REG_CTRL;
        1: a = REG_DIVISOR;
        2: a = REG_PERIOD;
        3: a = REG_DC;
        default: a = 16'($urandom);
      endcase
      issue(1'($urandom), a, 16'($urandom), int'($urandom_range(0, TIMEOUT + 3)), 16'($urandom));
    end
    drain();

    // Reset during REQ: bus cycle aborts with no clock edge, no response
    issue(1'b0, REG_CTRL, 16'h0000, NEVER, 16'h0000);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_cyc", bus.wb_cyc, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc",       bus.wb_cyc,    0);
    check("async_rst_stb",       bus.wb_stb,    0);
    check("async_rst_rsp_valid", bus.rsp_valid, 0);
    sticky = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mid_rst", bus.cmd_ready, 1);

    // Sticky ack while idle must not produce a response or a bus cycle
    repeat (10) @(negedge clk);
    check("sticky_no_rsp", bus.rsp_valid, 0);
    check("sticky_no_cyc", bus.wb_cyc,    0);
    sticky = 1'b0;

    issue(1'b0, REG_PERIOD, 16'h0000, 1, 16'h5A5A);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
